// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one registered bit per cycle out on x.
// Latency: first bit one cycle after acceptance; back-to-back words stream gap-free via a one-word holding register.
// Backpressure: in_ready drops while the holding register is full (and during reset).
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             take;
    logic             cur_bit;
    logic [WIDTH-1:0] shifted;

    assign in_ready = !hold_full && !rst;
    assign take     = in_valid && in_ready;
    assign busy     = (state == SHIFT) || hold_full;

    // The emitted end of sh is fixed by MSB_FIRST; the shift always moves toward it.
    assign cur_bit = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    x       <= IDLE_BIT;
                    x_valid <= 1'b0;
                    if (take) begin
                        sh    <= in_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    x       <= cur_bit;
                    x_valid <= 1'b1;
                    if (cnt == LAST) begin
                        // A full hold blocks in_ready, so take and drain never coincide.
                        if (hold_full) begin
                            sh        <= hold;
                            cnt       <= '0;
                            hold_full <= 1'b0;
                        end else if (take) begin
                            sh  <= in_data;
                            cnt <= '0;
                        end else begin
                            sh    <= shifted;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        sh  <= shifted;
                        cnt <= cnt + CW'(1);
                        if (take) begin
                            hold      <= in_data;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
